// File: rtl/seq_alu.sv
// Registered ALU: one operation per start/ready handshake. Logic ops finish in a single
// EXEC cycle; LSL/LSR walk the operand one bit per clock before the EXEC write-back.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             v,
  output logic             c,
  output logic             n,
  output logic             z
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;
  localparam logic [2:0] OP_LSR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EXEC} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [SHW-1:0]   r_cnt;
  logic             r_sout, r_shifted;
  logic [WIDTH-1:0] r_data;
  logic             r_v, r_c, r_n, r_z, r_done;

  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_wr_c, w_wr_v, w_c, w_v;

  assign w_amt      = data2[SHW-1:0];
  assign w_is_shift = (control == OP_LSL) || (control == OP_LSR);

  assign ready   = (r_state == S_IDLE);
  assign done    = r_done;
  assign dataOut = r_data;
  assign v       = r_v;
  assign c       = r_c;
  assign n       = r_n;
  assign z       = r_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (w_is_shift && w_amt != '0) ? S_SHIFT : S_EXEC;
      S_SHIFT: if (r_cnt == SHW'(1)) w_next = S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SUB reuses the adder as A + ~B + 1 so carry-out means "no borrow".
  assign w_sub = (r_op == OP_SUB);
  assign w_sum = {1'b0, r_a} + {1'b0, (w_sub ? ~r_b : r_b)} + (WIDTH+1)'(w_sub);

  always_comb begin
    w_res  = r_a;
    w_wr_c = 1'b0;
    w_wr_v = 1'b0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_wr_c = 1'b1;
        w_wr_v = 1'b1;
        w_c    = w_sum[WIDTH];
        w_v    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_wr_c = 1'b1;
        w_wr_v = 1'b1;
        w_c    = w_sum[WIDTH];
        w_v    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_LSL, OP_LSR: begin
        // r_a already holds the shifted value; a zero-length shift leaves carry alone.
        w_res  = r_a;
        w_wr_c = r_shifted;
        w_c    = r_sout;
      end
      default: w_res = r_a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= OP_NOP;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_sout    <= 1'b0;
      r_shifted <= 1'b0;
      r_data    <= '0;
      r_v       <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 1'b0;
      r_z       <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op      <= control;
          r_a       <= data1;
          r_b       <= data2;
          r_cnt     <= w_amt;
          r_shifted <= w_is_shift && (w_amt != '0);
        end
        S_SHIFT: begin
          if (r_op == OP_LSL) begin
            r_sout <= r_a[WIDTH-1];
            r_a    <= {r_a[WIDTH-2:0], 1'b0};
          end else begin
            r_sout <= r_a[0];
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - SHW'(1);
        end
        S_EXEC: begin
          r_done <= 1'b1;
          if (r_op != OP_NOP) begin
            r_data <= w_res;
            r_n    <= w_res[WIDTH-1];
            r_z    <= (w_res == '0);
          end
          if (w_wr_c) r_c <= w_c;
          if (w_wr_v) r_v <= w_v;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32) with hand-computed expectations.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  control;
  logic [31:0] data1, data2;
  logic        ready, done, v, c, n, z;
  logic [31:0] dataOut;

  int tests = 0;
  int errs  = 0;
  int lat;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, LSL = 3'd6, LSR = 3'd7;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .control(control),
    .data1(data1), .data2(data2), .ready(ready), .done(done),
    .dataOut(dataOut), .v(v), .c(c), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (caller is 1ns past an edge with ready high); return edges until done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start = 1'b1; control = op; data1 = a; data2 = b;
    step();
    start = 1'b0; control = NOP; data1 = 32'hDEAD_BEEF; data2 = 32'h1234_5678;
    cycles = 0;
    while (!done && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp_vcnz);
    chk(tag, {28'd0, v, c, n, z}, {28'd0, exp_vcnz});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; control = NOP; data1 = '0; data2 = '0;
    step(); step();
    chk("rst_data", dataOut, 32'h0);
    chk_flags("rst_flags", 4'b0000);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // 1. signed overflow on ADD
    run_op(ADD, 32'h7FFF_FFFF, 32'h1, lat);
    chk("add_ovf_lat", lat, 1);
    chk("add_ovf_data", dataOut, 32'h8000_0000);
    chk_flags("add_ovf_vcnz", 4'b1010);
    chk("add_ovf_ready", {31'd0, ready}, 32'd1);
    step();
    chk("add_ovf_done_pulse", {31'd0, done}, 32'd0);

    // 2. SUB equal and borrow
    run_op(SUB, 32'd5, 32'd5, lat);
    chk("sub_eq_data", dataOut, 32'h0);
    chk_flags("sub_eq_vcnz", 4'b0101);
    run_op(SUB, 32'd3, 32'd5, lat);
    chk("sub_borrow_data", dataOut, 32'hFFFF_FFFE);
    chk_flags("sub_borrow_vcnz", 4'b0010);

    // 3. shifts; set v first so it can be seen holding
    run_op(ADD, 32'h7FFF_FFFF, 32'h1, lat);
    chk_flags("pre_shift_vcnz", 4'b1010);
    run_op(LSL, 32'hF000_0001, 32'd4, lat);
    chk("lsl4_lat", lat, 5);
    chk("lsl4_data", dataOut, 32'h0000_0010);
    chk_flags("lsl4_vcnz", 4'b1100);
    run_op(LSR, 32'h3, 32'd1, lat);
    chk("lsr1_lat", lat, 2);
    chk("lsr1_data", dataOut, 32'h1);
    chk_flags("lsr1_vcnz", 4'b1100);
    run_op(LSR, 32'h8000_0000, 32'd31, lat);
    chk("lsr31_lat", lat, 32);
    chk("lsr31_data", dataOut, 32'h1);
    chk_flags("lsr31_vcnz", 4'b1000);

    // 4. carry-out, logic op holding c/v, NOP holding everything
    run_op(ADD, 32'hFFFF_FFFF, 32'h1, lat);
    chk("add_wrap_data", dataOut, 32'h0);
    chk_flags("add_wrap_vcnz", 4'b0101);
    run_op(AND_, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    chk("and_data", dataOut, 32'h0);
    chk_flags("and_vcnz", 4'b0101);
    run_op(OR_, 32'h8000_0000, 32'h0000_0001, lat);
    chk("or_data", dataOut, 32'h8000_0001);
    chk_flags("or_vcnz", 4'b0110);
    run_op(NOP, 32'h1234_5678, 32'h1, lat);
    chk("nop_lat", lat, 1);
    chk("nop_data", dataOut, 32'h8000_0001);
    chk_flags("nop_vcnz", 4'b0110);
    // shift amount field only: 0x20 -> N=0, carry held, one-cycle EXEC
    run_op(SUB, 32'd3, 32'd5, lat);
    run_op(LSL, 32'h4000_0000, 32'h20, lat);
    chk("lsl0_lat", lat, 1);
    chk("lsl0_data", dataOut, 32'h4000_0000);
    chk_flags("lsl0_vcnz", 4'b0000);

    // start while busy is dropped
    start = 1'b1; control = LSL; data1 = 32'h1; data2 = 32'd3;
    step();
    control = ADD; data1 = 32'h100; data2 = 32'h200;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin step(); lat++; end
    chk("busy_lat", lat, 4);
    chk("busy_data", dataOut, 32'h8);
    step(); step();
    chk("busy_no_extra_done", {31'd0, done}, 32'd0);
    chk("busy_data_hold", dataOut, 32'h8);

    // 5. reset in the middle of a long shift
    run_op(SUB, 32'd3, 32'd5, lat);
    start = 1'b1; control = LSL; data1 = 32'h1; data2 = 32'd20;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1; control = ADD; data1 = 32'h1; data2 = 32'h1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_ready", {31'd0, ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", dataOut, 32'h0);
    chk_flags("async_rst_vcnz", 4'b0000);
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    step();
    chk("async_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (25) begin
      step();
      if (done) chk("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    chk("post_rst_data", dataOut, 32'h0);

    // 6. back-to-back with start held high
    start = 1'b1; control = ADD; data1 = 32'd1; data2 = 32'd2;
    step();
    control = XOR_; data1 = 32'h0000_FF00; data2 = 32'h0000_0FF0;
    step();
    chk("b2b_add_done", {31'd0, done}, 32'd1);
    chk("b2b_add_data", dataOut, 32'd3);
    chk("b2b_add_ready", {31'd0, ready}, 32'd1);
    step();
    start = 1'b0;
    chk("b2b_gap_done", {31'd0, done}, 32'd0);
    step();
    chk("b2b_xor_done", {31'd0, done}, 32'd1);
    chk("b2b_xor_data", dataOut, 32'h0000_F0F0);
    chk_flags("b2b_xor_vcnz", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
